// File: rtl/mod8_seq_pkg.sv
// Shared definitions for the mod-8 counter run controller: FSM state
// encoding, counter modulus and terminal-count phases, and a small helper
// that maps a down-count phase onto the counter value it should show.
package mod8_seq_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_ERR  = 2'd3
    } seq_state_t;

    // Counter modulus and the Q values at which Qcc_n goes low
    localparam int         MOD   = 8;
    localparam logic [2:0] TC_UP = 3'd7;
    localparam logic [2:0] TC_DN = 3'd0;

    // Phase value that closes a lap (phase runs 0..MOD-1 within each lap)
    localparam logic [2:0] PHASE_LAST = 3'(MOD - 1);

    // Counting down from 0 visits 0,7,6..1, i.e. the two's complement of phase
    function automatic logic [2:0] neg_mod8(input logic [2:0] p);
        return 3'd0 - p;
    endfunction

endpackage

// File: rtl/mod8_expect.sv
// Expected counter outputs for a given lap phase and direction.
// Purely combinational; the top compares these against the live counter.
module mod8_expect
    import mod8_seq_pkg::*;
(
    input  logic [2:0] phase,
    input  logic       dir,        // 1 = counting up, 0 = counting down
    output logic [3:0] exp_Q,
    output logic       exp_Qcc_n
);

    logic [2:0] q_low;

    // Up: Q follows phase directly. Down: Q is the negated phase (0,7,6..1).
    assign q_low = dir ? phase : neg_mod8(phase);

    // Bit 3 of a mod-8 counter is never set
    assign exp_Q = {1'b0, q_low};

    // Terminal count is active-low and depends on the counting direction
    assign exp_Qcc_n = dir ? (q_low != TC_UP) : (q_low != TC_DN);

endmodule

// File: rtl/mod8_counter_sequencer.sv
// Run controller for the 4-bit mod-8 up/down counter. On start it drives
// the counter through laps_up full up-laps followed by laps_down full
// down-laps, checks the counter's Q and Qcc_n against the expected sequence
// every busy cycle, and raises a sticky err on the first disagreement.
module mod8_counter_sequencer
    import mod8_seq_pkg::*;
#(
    parameter int LAP_W = 4
) (
    input  logic             CP,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LAP_W-1:0] laps_up,
    input  logic [LAP_W-1:0] laps_down,
    input  logic [3:0]       cnt_Q,
    input  logic             cnt_Qcc_n,
    output logic             cnt_reset,
    output logic             cnt_M,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LAP_W:0]   lap_total
);

    seq_state_t       state_reg;
    logic [2:0]       phase_reg;
    logic [LAP_W-1:0] laps_up_reg;
    logic [LAP_W-1:0] laps_down_reg;
    logic [LAP_W-1:0] up_cnt_reg;
    logic [LAP_W-1:0] dn_cnt_reg;

    logic [3:0]       exp_Q;
    logic             exp_Qcc_n;
    logic             dir;
    logic [4:0]       diff_bits;
    logic             mismatch;
    logic             lap_end;
    logic [LAP_W:0]   up_cnt_next;
    logic [LAP_W:0]   dn_cnt_next;
    logic             last_up;
    logic             last_dn;

    // Direction used for the expected-value lookup follows the FSM state,
    // not cnt_M, so a stuck M line at the counter still shows as a mismatch.
    assign dir = (state_reg == ST_UP);

    mod8_expect u_expect (
        .phase     (phase_reg),
        .dir       (dir),
        .exp_Q     (exp_Q),
        .exp_Qcc_n (exp_Qcc_n)
    );

    // Per-bit disagreement between the live counter and the expected value
    for (genvar gi = 0; gi < 4; gi++) begin : g_q_diff
        assign diff_bits[gi] = cnt_Q[gi] ^ exp_Q[gi];
    end
    assign diff_bits[4] = cnt_Qcc_n ^ exp_Qcc_n;

    // Only meaningful while counting; ignored in IDLE/ERR by the FSM itself
    assign mismatch = |diff_bits;

    // Lap bookkeeping: a lap ends on the last phase; the lap that brings the
    // completed count up to the captured target is the last one.
    assign lap_end     = (phase_reg == PHASE_LAST);
    assign up_cnt_next = {1'b0, up_cnt_reg} + 1'b1;
    assign dn_cnt_next = {1'b0, dn_cnt_reg} + 1'b1;
    assign last_up     = (up_cnt_next == {1'b0, laps_up_reg});
    assign last_dn     = (dn_cnt_next == {1'b0, laps_down_reg});

    assign busy = (state_reg == ST_UP) || (state_reg == ST_DOWN);

    // Controller FSM with registered counter controls and status outputs
    always_ff @(posedge CP) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= 3'd0;
            laps_up_reg   <= '0;
            laps_down_reg <= '0;
            up_cnt_reg    <= '0;
            dn_cnt_reg    <= '0;
            cnt_reset     <= 1'b1;
            cnt_M         <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            lap_total     <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_ERR: begin
                    if (abort) begin
                        // Abort beats a same-cycle start; err stays sticky
                        state_reg <= ST_IDLE;
                        cnt_reset <= 1'b1;
                        cnt_M     <= 1'b1;
                    end else if (start) begin
                        laps_up_reg   <= laps_up;
                        laps_down_reg <= laps_down;
                        up_cnt_reg    <= '0;
                        dn_cnt_reg    <= '0;
                        phase_reg     <= 3'd0;
                        err           <= 1'b0;
                        lap_total     <= '0;
                        if (laps_up != '0) begin
                            state_reg <= ST_UP;
                            cnt_reset <= 1'b0;
                            cnt_M     <= 1'b1;
                        end else if (laps_down != '0) begin
                            state_reg <= ST_DOWN;
                            cnt_reset <= 1'b0;
                            cnt_M     <= 1'b0;
                        end else begin
                            // Empty run: finish immediately, counter stays in reset
                            state_reg <= ST_IDLE;
                            cnt_reset <= 1'b1;
                            cnt_M     <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end

                ST_UP: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        cnt_reset <= 1'b1;
                        cnt_M     <= 1'b1;
                    end else if (mismatch) begin
                        state_reg <= ST_ERR;
                        cnt_reset <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + 3'd1;
                        if (lap_end) begin
                            lap_total  <= lap_total + 1'b1;
                            up_cnt_reg <= up_cnt_next[LAP_W-1:0];
                            if (last_up) begin
                                if (laps_down_reg != '0) begin
                                    // Counter wraps 7->0 on this edge, then counts down
                                    state_reg <= ST_DOWN;
                                    cnt_M     <= 1'b0;
                                end else begin
                                    state_reg <= ST_IDLE;
                                    cnt_reset <= 1'b1;
                                    cnt_M     <= 1'b1;
                                    done      <= 1'b1;
                                end
                            end
                        end
                    end
                end

                ST_DOWN: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        cnt_reset <= 1'b1;
                        cnt_M     <= 1'b1;
                    end else if (mismatch) begin
                        state_reg <= ST_ERR;
                        cnt_reset <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + 3'd1;
                        if (lap_end) begin
                            lap_total  <= lap_total + 1'b1;
                            dn_cnt_reg <= dn_cnt_next[LAP_W-1:0];
                            if (last_dn) begin
                                state_reg <= ST_IDLE;
                                cnt_reset <= 1'b1;
                                cnt_M     <= 1'b1;
                                done      <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reset <= 1'b1;
                    cnt_M     <= 1'b1;
                end
            endcase
        end
    end

endmodule
